// File: rtl/life_generation_controller.sv
// Sequencer for the 16x16 Life engine: seeds the board, issues generations, captures results (`LIFE_AUTO_HALT_EN enables auto-halt).
// Latency: cmd_step -> step_en 1 cycle; next_valid -> board/gen_cnt 1 cycle. Backpressure: load_ready high only in IDLE.
module life_generation_controller #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned WAIT_MAX = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    input  logic [3:0]   load_row,
    input  logic [15:0]  load_data,
    output logic         load_ready,
    input  logic         cmd_run,
    input  logic         cmd_pause,
    input  logic         cmd_step,
    input  logic         cmd_clear,
    input  logic [255:0] next_board,
    input  logic         next_valid,
    output logic [255:0] board,
    output logic         step_en,
    output logic [31:0]  gen_cnt,
    output logic [2:0]   state,
    output logic         stable,
    output logic         extinct,
    output logic         error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

`ifdef LIFE_AUTO_HALT_EN
    localparam logic AUTO_HALT = 1'b1;
`else
    localparam logic AUTO_HALT = 1'b0;
`endif

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] WAIT_LAST = 32'(WAIT_MAX - 1);

    state_t        cur_state, nxt_state;
    logic          run_mode, run_mode_n;
    logic          pause_pending, pause_pending_n;
    logic [31:0]   tick_cnt, tick_cnt_n;
    logic [31:0]   wait_cnt, wait_cnt_n;
    logic [255:0]  board_n;
    logic [31:0]   gen_cnt_n;
    logic          stable_n, error_n;
    logic          res_same, res_zero;

    assign res_same   = (next_board == board);
    assign res_zero   = (next_board == '0);
    assign state      = cur_state;
    assign step_en    = (cur_state == S_ISSUE);
    assign load_ready = (cur_state == S_IDLE);
    assign extinct    = (board == '0);

    always_comb begin
        nxt_state       = cur_state;
        run_mode_n      = run_mode;
        pause_pending_n = pause_pending;
        tick_cnt_n      = tick_cnt;
        wait_cnt_n      = wait_cnt;
        board_n         = board;
        gen_cnt_n       = gen_cnt;
        stable_n        = stable;
        error_n         = error;

        if (cmd_clear) begin
            nxt_state       = S_IDLE;
            board_n         = '0;
            gen_cnt_n       = '0;
            stable_n        = 1'b0;
            error_n         = 1'b0;
            run_mode_n      = 1'b0;
            pause_pending_n = 1'b0;
            tick_cnt_n      = '0;
            wait_cnt_n      = '0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (load_valid) begin
                        board_n[{load_row, 4'h0} +: 16] = load_data;
                        stable_n = 1'b0;
                    end
                    // pause outranks run/step even though there is nothing to stop
                    if (!cmd_pause) begin
                        if (cmd_run) begin
                            run_mode_n = 1'b1;
                            tick_cnt_n = '0;
                            nxt_state  = S_RUN;
                        end else if (cmd_step) begin
                            run_mode_n = 1'b0;
                            nxt_state  = S_ISSUE;
                        end
                    end
                end
                S_RUN: begin
                    if (cmd_pause) begin
                        run_mode_n = 1'b0;
                        nxt_state  = S_IDLE;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        nxt_state  = S_ISSUE;
                    end else begin
                        tick_cnt_n = tick_cnt + 32'd1;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_n = '0;
                    nxt_state  = S_WAIT;
                    if (cmd_pause) pause_pending_n = 1'b1;
                end
                S_WAIT: begin
                    if (next_valid) begin
                        board_n   = next_board;
                        gen_cnt_n = gen_cnt + 32'd1;
                        stable_n  = res_same;
                        // a pause arriving with the result still stops after it
                        if (!run_mode || pause_pending || cmd_pause) begin
                            run_mode_n      = 1'b0;
                            pause_pending_n = 1'b0;
                            nxt_state       = S_IDLE;
                        end else if (AUTO_HALT && (res_same || res_zero)) begin
                            nxt_state = S_HALT;
                        end else begin
                            tick_cnt_n = '0;
                            nxt_state  = S_RUN;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        error_n         = 1'b1;
                        run_mode_n      = 1'b0;
                        pause_pending_n = 1'b0;
                        nxt_state       = S_IDLE;
                    end else begin
                        wait_cnt_n = wait_cnt + 32'd1;
                        if (cmd_pause) pause_pending_n = 1'b1;
                    end
                end
                S_HALT: begin
                    if (cmd_pause) begin
                        run_mode_n      = 1'b0;
                        pause_pending_n = 1'b0;
                        nxt_state       = S_IDLE;
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state     <= S_IDLE;
            run_mode      <= 1'b0;
            pause_pending <= 1'b0;
            tick_cnt      <= '0;
            wait_cnt      <= '0;
            board         <= '0;
            gen_cnt       <= '0;
            stable        <= 1'b0;
            error         <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            run_mode      <= run_mode_n;
            pause_pending <= pause_pending_n;
            tick_cnt      <= tick_cnt_n;
            wait_cnt      <= wait_cnt_n;
            board         <= board_n;
            gen_cnt       <= gen_cnt_n;
            stable        <= stable_n;
            error         <= error_n;
        end
    end

endmodule

// File: tb/tb_life_generation_controller.sv
// Directed bench for life_generation_controller with a Life-computing engine model of fixed latency.
module tb_life_generation_controller;

    localparam int TICK_DIV = 4;
    localparam int WAIT_MAX = 8;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_RUN = 3'd1, ST_ISSUE = 3'd2,
                           ST_WAIT = 3'd3, ST_HALT = 3'd4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [3:0]   load_row;
    logic [15:0]  load_data;
    logic         load_ready;
    logic         cmd_run, cmd_pause, cmd_step, cmd_clear;
    logic [255:0] next_board;
    logic         next_valid;
    logic [255:0] board;
    logic         step_en;
    logic [31:0]  gen_cnt;
    logic [2:0]   state;
    logic         stable, extinct, error;

    always #5 clk = ~clk;

    life_generation_controller #(.TICK_DIV(TICK_DIV), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_row(load_row), .load_data(load_data), .load_ready(load_ready),
        .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
        .next_board(next_board), .next_valid(next_valid),
        .board(board), .step_en(step_en), .gen_cnt(gen_cnt), .state(state),
        .stable(stable), .extinct(extinct), .error(error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [255:0] life(input logic [255:0] b);
        logic [255:0] o;
        int n;
        o = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
                            n += int'(b[(r + dr) * 16 + c + dc]);
                o[r * 16 + c] = b[r * 16 + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return o;
    endfunction

    // Engine model: result appears eng_lat falling edges after step_en is seen.
    int           eng_lat = 2;
    int           eng_cnt = 0;
    int           issues = 0;
    bit           eng_on = 1'b1;
    logic [255:0] eng_res;
    int           issue_cyc[$];

    initial begin
        next_valid = 1'b0;
        next_board = '0;
        eng_res    = '0;
        forever begin
            @(negedge clk);
            next_valid = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && eng_on) begin
                    next_valid = 1'b1;
                    next_board = eng_res;
                end
            end
            if (step_en) begin
                eng_cnt = eng_lat;
                eng_res = life(board);
                issues++;
                issue_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got time %0t required under 400000", $time);
        $fatal(1);
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string nm);
        int n = 0;
        while (state !== s && n < bound) begin
            step_clk();
            n++;
        end
        chk(nm, 256'(state), 256'(s));
    endtask

    task automatic wait_gen(input logic [31:0] g, input int bound, input string nm);
        int n = 0;
        while (gen_cnt !== g && n < bound) begin
            step_clk();
            n++;
        end
        chk(nm, 256'(gen_cnt), 256'(g));
    endtask

    task automatic load(input logic [3:0] row, input logic [15:0] dat);
        load_valid = 1'b1;
        load_row   = row;
        load_data  = dat;
        step_clk();
        load_valid = 1'b0;
    endtask

    task automatic pulse(input logic run, input logic pause, input logic stp, input logic clr);
        cmd_run = run; cmd_pause = pause; cmd_step = stp; cmd_clear = clr;
        step_clk();
        cmd_run = 1'b0; cmd_pause = 1'b0; cmd_step = 1'b0; cmd_clear = 1'b0;
    endtask

    typedef struct {
        logic        lv;
        logic [3:0]  row;
        logic [15:0] dat;
        logic [3:0]  cmd;       // {run, pause, step, clear}
        logic [3:0]  chk_row;
        logic [15:0] exp_row;
        logic [2:0]  exp_state;
        logic [2:0]  exp_flags; // {load_ready, step_en, extinct}
    } vec_t;

    function automatic vec_t mk(input logic lv, input logic [3:0] row, input logic [15:0] dat,
                                input logic [3:0] cmd, input logic [3:0] crow, input logic [15:0] erow,
                                input logic [2:0] est, input logic [2:0] flags);
        vec_t v;
        v.lv = lv; v.row = row; v.dat = dat; v.cmd = cmd;
        v.chk_row = crow; v.exp_row = erow; v.exp_state = est; v.exp_flags = flags;
        return v;
    endfunction

    vec_t         tbl[12];
    logic [255:0] blinker_h, blinker_v, block2, exp_b;
    int           base, c0, n;

    initial begin
        tbl[0]  = mk(1'b1, 4'd7,  16'h0380, 4'b0000, 4'd7,  16'h0380, ST_IDLE,  3'b100);
        tbl[1]  = mk(1'b1, 4'd0,  16'hFFFF, 4'b0000, 4'd0,  16'hFFFF, ST_IDLE,  3'b100);
        tbl[2]  = mk(1'b0, 4'd0,  16'h0000, 4'b1001, 4'd7,  16'h0000, ST_IDLE,  3'b101);
        tbl[3]  = mk(1'b1, 4'd15, 16'h8001, 4'b0000, 4'd15, 16'h8001, ST_IDLE,  3'b100);
        tbl[4]  = mk(1'b0, 4'd0,  16'h0000, 4'b1100, 4'd15, 16'h8001, ST_IDLE,  3'b100);
        tbl[5]  = mk(1'b0, 4'd0,  16'h0000, 4'b1000, 4'd15, 16'h8001, ST_RUN,   3'b000);
        tbl[6]  = mk(1'b1, 4'd15, 16'h1234, 4'b0000, 4'd15, 16'h8001, ST_RUN,   3'b000);
        tbl[7]  = mk(1'b0, 4'd0,  16'h0000, 4'b0010, 4'd15, 16'h8001, ST_RUN,   3'b000);
        tbl[8]  = mk(1'b0, 4'd0,  16'h0000, 4'b0000, 4'd15, 16'h8001, ST_RUN,   3'b000);
        tbl[9]  = mk(1'b0, 4'd0,  16'h0000, 4'b0000, 4'd15, 16'h8001, ST_ISSUE, 3'b010);
        tbl[10] = mk(1'b0, 4'd0,  16'h0000, 4'b0000, 4'd15, 16'h8001, ST_WAIT,  3'b000);
        tbl[11] = mk(1'b0, 4'd0,  16'h0000, 4'b0001, 4'd15, 16'h0000, ST_IDLE,  3'b101);

        blinker_h = '0; blinker_h[119] = 1'b1; blinker_h[120] = 1'b1; blinker_h[121] = 1'b1;
        blinker_v = '0; blinker_v[104] = 1'b1; blinker_v[120] = 1'b1; blinker_v[136] = 1'b1;
        block2    = '0; block2[83] = 1'b1; block2[84] = 1'b1; block2[99] = 1'b1; block2[100] = 1'b1;

        reset = 1'b1; load_valid = 1'b0; load_row = '0; load_data = '0;
        cmd_run = 1'b0; cmd_pause = 1'b0; cmd_step = 1'b0; cmd_clear = 1'b0;
        step_clk(); step_clk();
        chk("reset_state",   256'(state),   256'(ST_IDLE));
        chk("reset_board",   board,         '0);
        chk("reset_gen",     256'(gen_cnt), '0);
        chk("reset_flags",   256'({step_en, stable, error, extinct, load_ready}), 256'(5'b00011));
        reset = 1'b0;
        step_clk();

        // Per-cycle vectors: loads, command priority, RUN pacing, clear from WAIT.
        for (int i = 0; i < 12; i++) begin
            load_valid = tbl[i].lv; load_row = tbl[i].row; load_data = tbl[i].dat;
            {cmd_run, cmd_pause, cmd_step, cmd_clear} = tbl[i].cmd;
            step_clk();
            chk($sformatf("vec%0d_state", i), 256'(state), 256'(tbl[i].exp_state));
            chk($sformatf("vec%0d_row", i), 256'(board[int'(tbl[i].chk_row) * 16 +: 16]), 256'(tbl[i].exp_row));
            chk($sformatf("vec%0d_flags", i), 256'({load_ready, step_en, extinct}), 256'(tbl[i].exp_flags));
            chk($sformatf("vec%0d_gen", i), 256'(gen_cnt), '0);
        end
        load_valid = 1'b0;
        {cmd_run, cmd_pause, cmd_step, cmd_clear} = 4'b0000;
        repeat (6) step_clk();
        chk("late_result_ignored", 256'({gen_cnt, board}), '0);

        // Single step of a blinker.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        load(4'd7, 16'h0380);
        base = issues;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("step_latency", 256'({state, step_en}), 256'({ST_ISSUE, 1'b1}));
        wait_state(ST_IDLE, 20, "step_done");
        chk("step_board", board, blinker_v);
        chk("step_gen", 256'(gen_cnt), 256'(1));
        chk("step_stable", 256'(stable), '0);
        repeat (5) step_clk();
        chk("step_one_pulse", 256'(issues - base), 256'(1));

        // Free run: period = TICK_DIV RUN cycles + ISSUE + eng_lat WAIT cycles.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        load(4'd7, 16'h0380);
        issue_cyc.delete();
        base = issues;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_gen(32'd3, 100, "run_gen3");
        chk("run_issues3", 256'(issue_cyc.size()), 256'(3));
        if (issue_cyc.size() >= 3) begin
            chk("run_period1", 256'(issue_cyc[1] - issue_cyc[0]), 256'(TICK_DIV + 1 + 2));
            chk("run_period2", 256'(issue_cyc[2] - issue_cyc[1]), 256'(TICK_DIV + 1 + 2));
        end
        chk("run_board_g3", board, blinker_v);
        wait_state(ST_WAIT, 20, "run_wait4");
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_state(ST_IDLE, 20, "pause_idle");
        chk("pause_gen", 256'(gen_cnt), 256'(4));
        chk("pause_board", board, blinker_h);
        repeat (10) step_clk();
        chk("pause_stays", 256'({state, 32'(issues - base)}), 256'({ST_IDLE, 32'd4}));

        // Still-life block: halts with the feature enabled, keeps running otherwise.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        load(4'd5, 16'h0018);
        load(4'd6, 16'h0018);
        base = issues;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_gen(32'd1, 50, "block_gen1");
        chk("block_stable", 256'(stable), 256'(1));
`ifdef LIFE_AUTO_HALT_EN
        chk("block_halt", 256'(state), 256'(ST_HALT));
        repeat (20) step_clk();
        chk("halt_no_issue", 256'(issues - base), 256'(1));
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("halt_ignores_run", 256'(state), 256'(ST_HALT));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("halt_pause_idle", 256'(state), 256'(ST_IDLE));
`else
        chk("block_run", 256'(state), 256'(ST_RUN));
        repeat (20) step_clk();
        chk("block_keeps_issuing", 256'(issues - base >= 3), 256'(1));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_state(ST_IDLE, 20, "block_pause_idle");
`endif
        chk("block_board", board, block2);

        // Handshake timeout.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        load(4'd7, 16'h0380);
        eng_on = 1'b0;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_state(ST_WAIT, 5, "to_enter_wait");
        c0 = cyc;
        n = 0;
        while (error !== 1'b1 && n < 30) begin
            step_clk();
            n++;
        end
        chk("to_delay", 256'(cyc - c0), 256'(WAIT_MAX));
        chk("to_state", 256'(state), 256'(ST_IDLE));
        chk("to_board", board, blinker_h);
        chk("to_gen", 256'(gen_cnt), '0);
        repeat (3) step_clk();
        chk("to_sticky", 256'(error), 256'(1));
        eng_on = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_error", 256'(error), '0);

        // Clear during WAIT, result arrives afterwards.
        load(4'd7, 16'h0380);
        eng_lat = 6;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_state(ST_WAIT, 5, "late_enter_wait");
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) step_clk();
        chk("late_board", board, '0);
        chk("late_gen", 256'(gen_cnt), '0);
        chk("late_extinct_state", 256'({extinct, state}), 256'({1'b1, ST_IDLE}));
        eng_lat = 2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
